// File: rtl/alu_pkg.sv
// Shared opcodes and FSM encodings for the alu and its accumulator stage.
package alu_pkg;
   localparam logic [2:0] OP_PASS_A = 3'b000;
   localparam logic [2:0] OP_ADD    = 3'b010;
   localparam logic [2:0] OP_AND    = 3'b011;
   localparam logic [2:0] OP_XOR    = 3'b100;
   localparam logic [2:0] OP_PASS_B = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_EXEC = ST_EXEC,
      S_RESP = ST_RESP
   } state_t;
endpackage

// File: rtl/alu.sv
// Combinational 8-bit alu; unused opcodes pass operand A through.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] alu_out,
   output logic             a_is_zero
);
   always_comb begin
      alu_out = in_a;
      case (opcode)
         OP_ADD:    alu_out = in_a + in_b;
         OP_AND:    alu_out = in_a & in_b;
         OP_XOR:    alu_out = in_a ^ in_b;
         OP_PASS_B: alu_out = in_b;
         default:   alu_out = in_a;
      endcase
   end

   assign a_is_zero = (in_a == '0);
endmodule

// File: rtl/alu_acc_sequencer.sv
// Accumulator stage: accepts commands, drives the alu, captures and returns results.
module alu_acc_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_opcode,
   input  logic [WIDTH-1:0]     cmd_data,
   output logic [2:0]           alu_opcode,
   output logic [WIDTH-1:0]     alu_in_a,
   output logic [WIDTH-1:0]     alu_in_b,
   input  logic [WIDTH-1:0]     alu_result,
   input  logic                 alu_a_is_zero,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WIDTH-1:0]     rsp_data,
   output logic                 rsp_zero,
   output logic                 rsp_a_zero,
   output logic [WIDTH-1:0]     acc,
   output logic [CNT_WIDTH-1:0] op_count
);
   state_t               r_state;
   state_t               w_next;
   logic                 w_cmd_ready;
   logic                 w_accept;
   logic [WIDTH-1:0]     r_acc;
   logic [2:0]           r_opcode;
   logic [WIDTH-1:0]     r_in_b;
   logic                 r_rsp_zero;
   logic                 r_rsp_a_zero;
   logic [CNT_WIDTH-1:0] r_cnt;

   // In RESP a new command rides on the response handshake, avoiding an IDLE bubble.
   always_comb begin
      w_next      = r_state;
      w_cmd_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cmd_ready = 1'b1;
            if (cmd_valid) w_next = S_EXEC;
         end
         S_EXEC: w_next = S_RESP;
         S_RESP: begin
            w_cmd_ready = rsp_ready;
            if (rsp_ready) w_next = cmd_valid ? S_EXEC : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_accept = cmd_valid & w_cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_acc        <= '0;
         r_opcode     <= 3'b000;
         r_in_b       <= '0;
         r_rsp_zero   <= 1'b0;
         r_rsp_a_zero <= 1'b0;
         r_cnt        <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_opcode <= cmd_opcode;
            r_in_b   <= cmd_data;
         end
         if (r_state == S_EXEC) begin
            r_acc        <= alu_result;
            r_rsp_zero   <= (alu_result == '0);
            r_rsp_a_zero <= alu_a_is_zero;
            r_cnt        <= r_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign cmd_ready  = w_cmd_ready;
   assign alu_opcode = r_opcode;
   assign alu_in_a   = r_acc;
   assign alu_in_b   = r_in_b;
   assign rsp_valid  = (r_state == S_RESP);
   assign rsp_data   = r_acc;
   assign rsp_zero   = r_rsp_zero;
   assign rsp_a_zero = r_rsp_a_zero;
   assign acc        = r_acc;
   assign op_count   = r_cnt;
endmodule
